// File: rtl/imem_responder.sv
// Word-organised instruction memory responder: one outstanding request, LATENCY-cycle response.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module imem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        error
);

  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [3:0]  LatInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [31:0]       hold_q;
  logic              hold_we_q;
  logic              hold_err_q;
  logic              valid_q;
  logic              error_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              misalign;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic              unused_addr;

  assign ready  = (state_q != StWait);
  assign accept = mem_request & ready;
  assign idx    = address[ADDR_W+1:2];
  assign valid  = valid_q;
  assign rdata  = rdata_q;
  assign error  = error_q;

  // Upper bits wrap the address space; low bits only matter for the trap.
  assign unused_addr = ^{address[31:ADDR_W+2], address[1:0]};

`ifdef MISALIGN_TRAP_EN
  assign misalign = |address[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign rd_word = misalign ? Nop : mem[idx];

  always_ff @(posedge clk) begin
    if (!rst && accept && we_re && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      hold_q     <= 32'd0;
      hold_we_q  <= 1'b0;
      hold_err_q <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (accept) begin
        if (LATENCY == 1) begin
          // Respond straight from the accepting edge; no hold stage needed.
          state_q <= StResp;
          valid_q <= 1'b1;
          error_q <= misalign;
          if (!we_re) rdata_q <= rd_word;
        end else begin
          state_q    <= StWait;
          cnt_q      <= LatInit;
          hold_q     <= rd_word;
          hold_we_q  <= we_re;
          hold_err_q <= misalign;
        end
      end else begin
        unique case (state_q)
          StWait: begin
            if (cnt_q == 4'd1) begin
              state_q <= StResp;
              valid_q <= 1'b1;
              error_q <= hold_err_q;
              if (!hold_we_q) rdata_q <= hold_q;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          StResp:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: LATENCY=2 instance for the main sequence, LATENCY=1
// instance for streaming reads.
module tb_imem_responder;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    logic        err;
    int          due;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_request = 1'b0, we_re = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [31:0] address = 32'd0, wdata = 32'd0;
  logic        ready, valid, error;
  logic [31:0] rdata;

  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [3:0]  r1_mask = 4'hf;
  logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
  logic        r1_ready, r1_valid, r1_error;
  logic [31:0] r1_rdata;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] last_rd = 32'd0;
  logic [31:0] model [1024];
  resp_t       exp_q [$];

  imem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .mem_request(mem_request), .we_re(we_re), .mask(mask),
    .address(address), .wdata(wdata), .ready(ready), .valid(valid), .rdata(rdata),
    .error(error)
  );

  imem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_request(r1_req), .we_re(r1_we), .mask(r1_mask),
    .address(r1_addr), .wdata(r1_wdata), .ready(r1_ready), .valid(r1_valid), .rdata(r1_rdata),
    .error(r1_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Response monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    resp_t e;
    if (rst) begin
      last_rd = 32'd0;
    end else if (valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("latency", 32'(cyc), 32'(e.due));
        if (e.is_rd) begin
          check("rdata", rdata, e.data);
          last_rd = e.data;
        end else begin
          check("rdata_hold", rdata, last_rd);
        end
        check("error", 32'(error), 32'(e.err));
      end
    end else begin
      check("error_idle", 32'(error), 32'd0);
    end
  end

  function automatic logic misaligned(input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_resp();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    check("resp_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Drive one request on the LATENCY=2 instance and push its expected response.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d);
    resp_t e;
    logic [9:0] idx;
    logic mis;
    idx = a[11:2];
    mis = misaligned(a);
    check("ready_accept", 32'(ready), 32'd1);
    mem_request = 1'b1; we_re = w; address = a; mask = m; wdata = d;
    e.is_rd = !w;
    e.err   = mis;
    e.due   = cyc + 2;
    e.data  = 32'd0;
    if (w) begin
      if (!mis) begin
        for (int i = 0; i < 4; i++) if (m[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      end
    end else begin
      e.data = mis ? 32'h0000_0013 : model[idx];
    end
    exp_q.push_back(e);
    @(negedge clk);
    mem_request = 1'b1;
    address = 32'h0000_0ffc; wdata = 32'hffff_ffff; we_re = ~w; mask = 4'hf;
    check("ready_wait", 32'(ready), 32'd0);
    check("valid_wait", 32'(valid), 32'd0);
    #1;
    mem_request = 1'b0;
    wait_resp();
  endtask

  logic [31:0] l1_data [3];

  initial begin
    l1_data[0] = 32'h0a0a_0001;
    l1_data[1] = 32'h0b0b_0002;
    l1_data[2] = 32'h0c0c_0003;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_error", 32'(error), 32'd0);
    end

    issue(1'b1, 32'h8, 4'hf, 32'hdead_beef);
    issue(1'b0, 32'h8, 4'hf, 32'h0);
    issue(1'b1, 32'h8, 4'h1, 32'h0000_00aa);
    issue(1'b0, 32'h8, 4'hf, 32'h0);
    issue(1'b1, 32'h1000, 4'hf, 32'h1122_3344);
    issue(1'b0, 32'h0, 4'hf, 32'h0);
    issue(1'b1, 32'h4, 4'hf, 32'h5566_7788);
    issue(1'b0, 32'h6, 4'hf, 32'h0);
    issue(1'b1, 32'h4, 4'h0, 32'hffff_ffff);
    issue(1'b0, 32'h4, 4'hf, 32'h0);

    // Reset while a read is in WAIT: the response must never appear.
    mem_request = 1'b1; we_re = 1'b0; address = 32'h8;
    @(negedge clk);
    mem_request = 1'b0;
    check("rst_mid_wait", 32'(ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 32'(valid), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(valid), 32'd0);
    end
    check("post_rst_ready", 32'(ready), 32'd1);
    issue(1'b0, 32'h8, 4'hf, 32'h0);

    // LATENCY=1: request held high streams three writes then three reads.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      r1_req = 1'b1; r1_we = (i < 3); r1_mask = 4'hf;
      r1_addr = 32'(4 * (i % 3)); r1_wdata = l1_data[i % 3];
      @(negedge clk);
      check("l1_valid", 32'(r1_valid), 32'd1);
      check("l1_ready", 32'(r1_ready), 32'd1);
      check("l1_error", 32'(r1_error), 32'd0);
      if (i >= 3) check("l1_rdata", r1_rdata, l1_data[i - 3]);
    end
    r1_req = 1'b0;
    @(negedge clk);
    check("l1_idle_valid", 32'(r1_valid), 32'd0);
    check("l1_rdata_hold", r1_rdata, l1_data[2]);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
